// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for the integer pipeline control
package pipe_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        LU   = 2'd1,
        WAIT = 2'd2
    } state_e;

    localparam logic [4:0] REG_X0 = 5'd0;
    localparam int         PC_W   = 8;
    localparam int         XLEN   = 64;

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - load-use comparator between the ID and EX stages
module hazard_detect
    import pipe_pkg::*;
(
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    input  logic [4:0] ex_WReg1,
    input  logic       ex_WRegEn,
    input  logic       ex_mem_to_reg,
    output logic       lu
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = id_use_rs1 && (id_rs1 == ex_WReg1);
    assign rs2_hit = id_use_rs2 && (id_rs2 == ex_WReg1);

    // x0 is never a real producer, so a load targeting it cannot create a hazard
    assign lu = ex_mem_to_reg && ex_WRegEn && (ex_WReg1 != REG_X0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush sequencer for the 5-stage pipeline
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int LOAD_STALL  = 1,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic            id_use_rs1,
    input  logic            id_use_rs2,
    input  logic [4:0]      ex_WReg1,
    input  logic            ex_WRegEn,
    input  logic            ex_mem_to_reg,
    input  logic            ex_redirect,
    input  logic [PC_W-1:0] ex_target,
    input  logic            mem_req,
    input  logic            mem_ready,
    output logic            pc_we,
    output logic            pc_sel,
    output logic [PC_W-1:0] pc_target,
    output logic            ifid_we,
    output logic            ifid_flush,
    output logic            idex_we,
    output logic            idex_bubble,
    output logic            exmem_we,
    output logic            memwb_bubble,
    output logic            mem_timeout,
    output logic [15:0]     stall_cnt
);

    state_e      state_q, state_d;
    state_e      ret_state_q, ret_state_d;
    state_e      eff_state;
    logic [1:0]  lu_cnt_q, lu_cnt_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        mem_timeout_q, mem_timeout_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic        lu;
    logic        freeze;

    hazard_detect u_hazard_detect (
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_use_rs1    (id_use_rs1),
        .id_use_rs2    (id_use_rs2),
        .ex_WReg1      (ex_WReg1),
        .ex_WRegEn     (ex_WRegEn),
        .ex_mem_to_reg (ex_mem_to_reg),
        .lu            (lu)
    );

    assign freeze      = mem_req && !mem_ready;
    assign pc_target   = ex_target;
    assign mem_timeout = mem_timeout_q;
    assign stall_cnt   = stall_cnt_q;

    always_comb begin
        pc_we         = 1'b1;
        pc_sel        = 1'b0;
        ifid_we       = 1'b1;
        ifid_flush    = 1'b0;
        idex_we       = 1'b1;
        idex_bubble   = 1'b0;
        exmem_we      = 1'b1;
        memwb_bubble  = 1'b0;
        state_d       = state_q;
        ret_state_d   = ret_state_q;
        lu_cnt_d      = lu_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = mem_timeout_q;
        // leaving WAIT, the release cycle is decoded as the saved state
        eff_state     = (state_q == WAIT) ? ret_state_q : state_q;

        if (freeze) begin
            pc_we        = 1'b0;
            ifid_we      = 1'b0;
            idex_we      = 1'b0;
            exmem_we     = 1'b0;
            memwb_bubble = 1'b1;
            state_d      = WAIT;
            if (state_q != WAIT) begin
                ret_state_d = state_q;
            end
            if (wait_cnt_q != 8'hFF) begin
                wait_cnt_d = wait_cnt_q + 8'd1;
            end
            if (wait_cnt_d == 8'(MEM_TIMEOUT)) begin
                mem_timeout_d = 1'b1;
            end
        end else begin
            wait_cnt_d = 8'd0;
            state_d    = RUN;
            if (ex_redirect) begin
                pc_sel      = 1'b1;
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
                lu_cnt_d    = 2'd0;
            end else begin
                case (eff_state)
                    RUN: begin
                        if (lu) begin
                            pc_we       = 1'b0;
                            ifid_we     = 1'b0;
                            idex_bubble = 1'b1;
                            if (LOAD_STALL > 1) begin
                                state_d  = LU;
                                lu_cnt_d = 2'(LOAD_STALL - 1);
                            end
                        end
                    end
                    LU: begin
                        pc_we       = 1'b0;
                        ifid_we     = 1'b0;
                        idex_bubble = 1'b1;
                        if (lu_cnt_q > 2'd1) begin
                            state_d  = LU;
                            lu_cnt_d = lu_cnt_q - 2'd1;
                        end else begin
                            lu_cnt_d = 2'd0;
                        end
                    end
                    default: state_d = RUN;
                endcase
            end
        end

        if (RST) begin
            pc_we        = 1'b0;
            pc_sel       = 1'b0;
            ifid_we      = 1'b0;
            idex_we      = 1'b0;
            exmem_we     = 1'b0;
            ifid_flush   = 1'b1;
            idex_bubble  = 1'b1;
            memwb_bubble = 1'b1;
        end

        stall_cnt_d = stall_cnt_q;
        if (!pc_we && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= RUN;
            ret_state_q   <= RUN;
            lu_cnt_q      <= 2'd0;
            wait_cnt_q    <= 8'd0;
            mem_timeout_q <= 1'b0;
            stall_cnt_q   <= 16'd0;
        end else begin
            state_q       <= state_d;
            ret_state_q   <= ret_state_d;
            lu_cnt_q      <= lu_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed-vector bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

    logic       CLK;
    logic       RST;
    logic [4:0] id_rs1, id_rs2, ex_WReg1;
    logic       id_use_rs1, id_use_rs2, ex_WRegEn, ex_mem_to_reg, ex_redirect;
    logic [7:0] ex_target;
    logic       mem_req, mem_ready;

    logic        pc_we_a, pc_sel_a, ifid_we_a, ifid_flush_a, idex_we_a, idex_bubble_a;
    logic        exmem_we_a, memwb_bubble_a, mem_timeout_a;
    logic [7:0]  pc_target_a;
    logic [15:0] stall_cnt_a;
    logic        pc_we_b, pc_sel_b, ifid_we_b, ifid_flush_b, idex_we_b, idex_bubble_b;
    logic        exmem_we_b, memwb_bubble_b, mem_timeout_b;
    logic [7:0]  pc_target_b;
    logic [15:0] stall_cnt_b;

    int checks = 0;
    int failures = 0;

    // {pc_we, pc_sel, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_we, memwb_bubble}
    localparam logic [7:0] V_RUN = 8'b1010_1010;
    localparam logic [7:0] V_RST = 8'b0001_0101;
    localparam logic [7:0] V_LU  = 8'b0000_1110;
    localparam logic [7:0] V_RED = 8'b1111_1110;
    localparam logic [7:0] V_FRZ = 8'b0000_0001;

    logic [7:0] ov_a, ov_b;
    assign ov_a = {pc_we_a, pc_sel_a, ifid_we_a, ifid_flush_a, idex_we_a, idex_bubble_a, exmem_we_a, memwb_bubble_a};
    assign ov_b = {pc_we_b, pc_sel_b, ifid_we_b, ifid_flush_b, idex_we_b, idex_bubble_b, exmem_we_b, memwb_bubble_b};

    pipe_hazard_ctrl #(.LOAD_STALL(1), .MEM_TIMEOUT(4)) dut_a (
        .CLK(CLK), .RST(RST), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_WReg1(ex_WReg1),
        .ex_WRegEn(ex_WRegEn), .ex_mem_to_reg(ex_mem_to_reg), .ex_redirect(ex_redirect),
        .ex_target(ex_target), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_we(pc_we_a), .pc_sel(pc_sel_a), .pc_target(pc_target_a), .ifid_we(ifid_we_a),
        .ifid_flush(ifid_flush_a), .idex_we(idex_we_a), .idex_bubble(idex_bubble_a),
        .exmem_we(exmem_we_a), .memwb_bubble(memwb_bubble_a),
        .mem_timeout(mem_timeout_a), .stall_cnt(stall_cnt_a)
    );

    pipe_hazard_ctrl #(.LOAD_STALL(2), .MEM_TIMEOUT(64)) dut_b (
        .CLK(CLK), .RST(RST), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_WReg1(ex_WReg1),
        .ex_WRegEn(ex_WRegEn), .ex_mem_to_reg(ex_mem_to_reg), .ex_redirect(ex_redirect),
        .ex_target(ex_target), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_we(pc_we_b), .pc_sel(pc_sel_b), .pc_target(pc_target_b), .ifid_we(ifid_we_b),
        .ifid_flush(ifid_flush_b), .idex_we(idex_we_b), .idex_bubble(idex_bubble_b),
        .exmem_we(exmem_we_b), .memwb_bubble(memwb_bubble_b),
        .mem_timeout(mem_timeout_b), .stall_cnt(stall_cnt_b)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_WReg1 = 5'd0; ex_WRegEn = 1'b0; ex_mem_to_reg = 1'b0;
        ex_redirect = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic set_lu();
        ex_mem_to_reg = 1'b1; ex_WRegEn = 1'b1; ex_WReg1 = 5'd5;
        id_use_rs2 = 1'b1; id_rs2 = 5'd5;
    endtask

    initial begin
        idle();
        RST = 1'b1;
        ex_target = 8'h5A;
        step();
        #2;
        check("rst_out0", 32'(ov_a), 32'(V_RST));
        check("rst_target", 32'(pc_target_a), 32'h5A);
        step();
        #2;
        check("rst_out1", 32'(ov_a), 32'(V_RST));
        check("rst_stall", 32'(stall_cnt_a), 32'd0);
        check("rst_tmo", 32'(mem_timeout_a), 32'd0);
        step();

        RST = 1'b0;
        #2;
        check("run_a", 32'(ov_a), 32'(V_RUN));
        check("run_b", 32'(ov_b), 32'(V_RUN));
        step();

        set_lu();
        #2;
        check("lu_a", 32'(ov_a), 32'(V_LU));
        check("lu_b0", 32'(ov_b), 32'(V_LU));
        step();
        idle();
        #2;
        check("lu_done_a", 32'(ov_a), 32'(V_RUN));
        check("lu_b1", 32'(ov_b), 32'(V_LU));
        check("lu_stall_a", 32'(stall_cnt_a), 32'd1);
        step();
        #2;
        check("lu_done_b", 32'(ov_b), 32'(V_RUN));
        check("lu_stall_b", 32'(stall_cnt_b), 32'd2);
        step();

        set_lu();
        ex_WReg1 = 5'd0;
        id_rs2 = 5'd0;
        #2;
        check("x0_a", 32'(ov_a), 32'(V_RUN));
        check("x0_b", 32'(ov_b), 32'(V_RUN));
        step();

        set_lu();
        ex_redirect = 1'b1;
        ex_target = 8'h40;
        #2;
        check("redir_out", 32'(ov_a), 32'(V_RED));
        check("redir_target", 32'(pc_target_a), 32'h40);
        step();
        idle();
        #2;
        check("redir_stall", 32'(stall_cnt_a), 32'd1);

        mem_req = 1'b1;
        ex_redirect = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #2;
            check("frz_a", 32'(ov_a), 32'(V_FRZ));
            check("frz_b", 32'(ov_b), 32'(V_FRZ));
            step();
        end
        mem_ready = 1'b1;
        #2;
        check("frz_redir", 32'(ov_a), 32'(V_RED));
        check("frz_stall", 32'(stall_cnt_a), 32'd4);
        step();
        idle();
        #2;
        check("frz_tmo", 32'(mem_timeout_a), 32'd0);

        mem_req = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            step();
            #2;
            check($sformatf("tmo_%0d", i), 32'(mem_timeout_a), (i >= 4) ? 32'd1 : 32'd0);
        end
        mem_ready = 1'b1;
        #2;
        check("tmo_release", 32'(ov_a), 32'(V_RUN));
        step();
        idle();
        #2;
        check("tmo_sticky", 32'(mem_timeout_a), 32'd1);
        check("tmo_b", 32'(mem_timeout_b), 32'd0);
        step();

        set_lu();
        #2;
        check("ls2_lu0", 32'(ov_b), 32'(V_LU));
        step();
        idle();
        mem_req = 1'b1;
        #2;
        check("ls2_frz", 32'(ov_b), 32'(V_FRZ));
        step();
        mem_req = 1'b0;
        #2;
        check("ls2_resume", 32'(ov_b), 32'(V_LU));
        step();
        #2;
        check("ls2_done", 32'(ov_b), 32'(V_RUN));
        step();

        set_lu();
        #2;
        check("rstlu_lu0", 32'(ov_b), 32'(V_LU));
        step();
        idle();
        RST = 1'b1;
        #2;
        check("rstlu_rst", 32'(ov_b), 32'(V_RST));
        step();
        RST = 1'b0;
        #2;
        check("rstlu_run", 32'(ov_b), 32'(V_RUN));
        check("rstlu_stall", 32'(stall_cnt_b), 32'd0);
        check("rst_tmo_clr", 32'(mem_timeout_a), 32'd0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
